// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe DMA read path.
// The descriptor length field is wide enough for any supported LEN_W (up to 16).
package pcie_dma_pkg;

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned BEAT_BYTES = 16;
  localparam int unsigned DESC_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } rd_arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DESC_LEN_W-1:0] len;
  } rd_desc_t;

  // Clear the byte offset within a beat.
  function automatic logic [ADDR_W-1:0] beatAlign(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/pcie_rd_arbiter_if.sv
// Requester and read-controller signal bundle for pcie_rd_arbiter.
// master = the arbiter, slave = DMA engines plus controller side.
interface pcie_rd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 8
);
  import pcie_dma_pkg::*;

  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*LEN_W-1:0]  ReqLen;
  logic [NUM_REQ-1:0]        ReqAck;
  logic [DATA_W-1:0]         RspData;
  logic [NUM_REQ-1:0]        RspValid;
  logic [NUM_REQ-1:0]        RspErr;
  logic [NUM_REQ-1:0]        RspDone;
  logic                      RdRqValid;
  logic [ADDR_W-1:0]         RdRqAddr;
  logic [DATA_W-1:0]         RdRqData;
  logic                      RdRqReady;
  logic                      RdRqErr;

  modport master (
    input  ReqValid, ReqAddr, ReqLen, RdRqData, RdRqReady, RdRqErr,
    output ReqAck, RspData, RspValid, RspErr, RspDone, RdRqValid, RdRqAddr
  );

  modport slave (
    output ReqValid, ReqAddr, ReqLen, RdRqData, RdRqReady, RdRqErr,
    input  ReqAck, RspData, RspValid, RspErr, RspDone, RdRqValid, RdRqAddr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester after lastGrant, with wrap-around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] lastGrant,
  output logic [NUM_REQ-1:0]         grantOH,
  output logic [$clog2(NUM_REQ)-1:0] grantIdx,
  output logic                       anyReq
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found    = 1'b0;
    cand     = '0;
    grantIdx = '0;
    anyReq   = |req;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(lastGrant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    grantOH = anyReq ? (NUM_REQ'(1) << grantIdx) : '0;
  end

endmodule

// File: rtl/pcie_rd_arbiter.sv
// Round-robin burst sequencer sharing the PCIe read-request port between DMA requesters.
// One descriptor per grant, one 16-byte read per beat, a DONE cycle between bursts.
module pcie_rd_arbiter
  import pcie_dma_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned TIMEOUT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  pcie_rd_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  // Abort fires on the cycle the watchdog would reach its all-ones value.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  rd_arb_state_e         state, stateNxt;
  rd_desc_t              desc, descNxt;
  logic [IDX_W-1:0]      grant, grantNxt;
  logic [IDX_W-1:0]      lastGrant, lastGrantNxt;
  logic [DESC_LEN_W-1:0] beatCnt, beatNxt;
  logic [TIMEOUT_W-1:0]  wdog, wdogNxt;
  logic                  rdRqValid, rdRqValidNxt;
  logic [DATA_W-1:0]     rspData, rspDataNxt;
  logic [NUM_REQ-1:0]    reqAck, reqAckNxt;
  logic [NUM_REQ-1:0]    rspValid, rspValidNxt;
  logic [NUM_REQ-1:0]    rspErr, rspErrNxt;
  logic [NUM_REQ-1:0]    rspDone, rspDoneNxt;

  logic [NUM_REQ-1:0]    arbOH;
  logic [IDX_W-1:0]      arbIdx;
  logic                  anyReq;
  logic [NUM_REQ-1:0]    grantOH;
  logic [ADDR_W-1:0]     selAddr;
  logic [LEN_W-1:0]      selLen;
  logic                  lastBeat;
  logic                  abort;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.ReqValid),
    .lastGrant (lastGrant),
    .grantOH   (arbOH),
    .grantIdx  (arbIdx),
    .anyReq    (anyReq)
  );

  // Descriptor of the arbitration winner; only meaningful in IDLE.
  assign selAddr  = bus.ReqAddr[32'(arbIdx) * ADDR_W +: ADDR_W];
  assign selLen   = bus.ReqLen[32'(arbIdx) * LEN_W +: LEN_W];
  assign grantOH  = NUM_REQ'(1) << grant;
  assign lastBeat = (beatCnt == desc.len - DESC_LEN_W'(1));
  // Error wins over Ready; a silent watchdog expiry behaves like an error.
  assign abort    = bus.RdRqErr | (~bus.RdRqReady & (wdog == WDOG_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      desc      <= '0;
      grant     <= '0;
      lastGrant <= IDX_W'(NUM_REQ - 1);
      beatCnt   <= '0;
      wdog      <= '0;
      rdRqValid <= 1'b0;
      rspData   <= '0;
      reqAck    <= '0;
      rspValid  <= '0;
      rspErr    <= '0;
      rspDone   <= '0;
    end else begin
      state     <= stateNxt;
      desc      <= descNxt;
      grant     <= grantNxt;
      lastGrant <= lastGrantNxt;
      beatCnt   <= beatNxt;
      wdog      <= wdogNxt;
      rdRqValid <= rdRqValidNxt;
      rspData   <= rspDataNxt;
      reqAck    <= reqAckNxt;
      rspValid  <= rspValidNxt;
      rspErr    <= rspErrNxt;
      rspDone   <= rspDoneNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    descNxt      = desc;
    grantNxt     = grant;
    lastGrantNxt = lastGrant;
    beatNxt      = beatCnt;
    wdogNxt      = wdog;
    rdRqValidNxt = rdRqValid;
    rspDataNxt   = rspData;
    reqAckNxt    = '0;
    rspValidNxt  = '0;
    rspErrNxt    = '0;
    rspDoneNxt   = '0;

    case (state)
      IDLE: begin
        if (anyReq) begin
          grantNxt     = arbIdx;
          reqAckNxt    = arbOH;
          descNxt.addr = beatAlign(selAddr);
          descNxt.len  = DESC_LEN_W'(selLen);
          beatNxt      = '0;
          wdogNxt      = '0;
          if (selLen == '0) begin
            stateNxt = DONE;
          end else begin
            stateNxt     = ISSUE;
            rdRqValidNxt = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (abort) begin
          rspErrNxt    = grantOH;
          rdRqValidNxt = 1'b0;
          stateNxt     = DONE;
        end else if (bus.RdRqReady) begin
          rspValidNxt  = grantOH;
          rspDataNxt   = bus.RdRqData;
          beatNxt      = beatCnt + DESC_LEN_W'(1);
          wdogNxt      = '0;
          descNxt.addr = desc.addr + ADDR_W'(BEAT_BYTES);
          if (lastBeat) begin
            rdRqValidNxt = 1'b0;
            stateNxt     = DONE;
          end
        end else begin
          wdogNxt = wdog + TIMEOUT_W'(1);
        end
      end

      DONE: begin
        rdRqValidNxt = 1'b0;
        rspDoneNxt   = grantOH;
        lastGrantNxt = grant;
        stateNxt     = IDLE;
      end

      default: begin
        rdRqValidNxt = 1'b0;
        stateNxt     = IDLE;
      end
    endcase
  end

  assign bus.ReqAck    = reqAck;
  assign bus.RspData   = rspData;
  assign bus.RspValid  = rspValid;
  assign bus.RspErr    = rspErr;
  assign bus.RspDone   = rspDone;
  assign bus.RdRqValid = rdRqValid;
  assign bus.RdRqAddr  = desc.addr;

endmodule

// File: tb/tb_pcie_rd_arbiter.sv
// Randomized bench for pcie_rd_arbiter against a transaction-level model of
// grants, beat addresses, returned data, aborts, timeouts and burst completion.
module tb_pcie_rd_arbiter;
  import pcie_dma_pkg::*;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned LENW        = 8;
  localparam int unsigned TOW         = 4;
  localparam int          TIMEOUT_CYC = (1 << TOW) - 1;
  localparam int          CYCLES      = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_rd_arbiter_if #(.NUM_REQ(NREQ), .LEN_W(LENW)) bus ();

  pcie_rd_arbiter #(.NUM_REQ(NREQ), .LEN_W(LENW), .TIMEOUT_W(TOW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Pending descriptors per requester
  bit [NREQ-1:0] pend;
  logic [63:0]   pAddr [NREQ];
  int            pLen  [NREQ];

  // Port ownership as seen from outside: free, streaming a burst, or closing it
  int          lastG;
  bit          portFree, inBurst, closing, stall;
  int          g, bLen, bBeat, silent, nBursts, cyc;
  logic [63:0] bAddr;
  bit          didReset;

  // Expected outputs for the coming cycle
  logic [NREQ-1:0] eAck, eRspV, eErr, eDone;
  logic            eValid;
  logic [63:0]     eAddr;
  logic [127:0]    eData;

  // Controller responses driven this cycle
  bit           dReady, dErr;
  logic [127:0] dData;

  function automatic int rrPick(input bit [NREQ-1:0] req, input int last);
    int idx;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (last + k) % int'(NREQ);
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic setDesc(input int r, input logic [63:0] a, input int len);
    pend[r]  = 1'b1;
    pAddr[r] = a;
    pLen[r]  = len;
    bus.ReqAddr[r*64 +: 64]     = a;
    bus.ReqLen[r*LENW +: LENW]  = LENW'(len);
  endtask

  task automatic randDesc(input int r);
    logic [63:0] a;
    int          len;
    if ($urandom_range(0, 5) == 0) a = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
    else                           a = {$urandom, $urandom};
    len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
    setDesc(r, a, len);
  endtask

  task automatic checkOutputs();
    checkEq("ReqAck", bus.ReqAck, eAck);
    checkEq("RdRqValid", bus.RdRqValid, eValid);
    if (eValid) checkEq("RdRqAddr", bus.RdRqAddr, eAddr);
    checkEq("RspValid", bus.RspValid, eRspV);
    if (eRspV != '0) checkEq("RspData", bus.RspData, eData);
    checkEq("RspErr", bus.RspErr, eErr);
    checkEq("RspDone", bus.RspDone, eDone);
  endtask

  task automatic drive();
    int r;
    if (cyc >= 40) begin
      for (int q = 0; q < int'(NREQ); q++)
        if (!pend[q] && $urandom_range(0, 3) == 0) randDesc(q);
    end
    bus.ReqValid = pend;
    dReady = 1'b0;
    dErr   = 1'b0;
    dData  = {$urandom, $urandom, $urandom, $urandom};
    if (inBurst && !stall) begin
      r      = int'($urandom_range(0, 63));
      dReady = (r < 28) || (r == 63);
      dErr   = (r >= 62);
    end
    bus.RdRqReady = dReady;
    bus.RdRqErr   = dErr;
    bus.RdRqData  = dData;
  endtask

  // Work out what the port must show next cycle given this cycle's inputs.
  task automatic predict();
    eAck = '0; eRspV = '0; eErr = '0; eDone = '0; eValid = 1'b0;
    if (closing) begin
      eDone[g] = 1'b1;
      lastG    = g;
      closing  = 1'b0;
      portFree = 1'b1;
    end else if (inBurst) begin
      if (dErr || (!dReady && silent + 1 == TIMEOUT_CYC)) begin
        eErr[g] = 1'b1;
        inBurst = 1'b0;
        closing = 1'b1;
      end else if (dReady) begin
        eRspV[g] = 1'b1;
        eData    = dData;
        bBeat++;
        silent   = 0;
        if (bBeat == bLen) begin
          inBurst = 1'b0;
          closing = 1'b1;
        end else begin
          eValid = 1'b1;
          eAddr  = bAddr + 64'(16 * bBeat);
        end
      end else begin
        silent++;
        eValid = 1'b1;
        eAddr  = bAddr + 64'(16 * bBeat);
      end
    end else if (portFree && pend != '0) begin
      g        = rrPick(pend, lastG);
      eAck[g]  = 1'b1;
      pend[g]  = 1'b0;
      bAddr    = pAddr[g] & ~64'hF;
      bLen     = pLen[g];
      bBeat    = 0;
      silent   = 0;
      stall    = (nBursts == 3) || ($urandom_range(0, 11) == 0);
      nBursts++;
      portFree = 1'b0;
      if (bLen == 0) closing = 1'b1;
      else begin
        inBurst = 1'b1;
        eValid  = 1'b1;
        eAddr   = bAddr;
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkEq("rst ReqAck", bus.ReqAck, '0);
    checkEq("rst RdRqValid", bus.RdRqValid, '0);
    checkEq("rst RdRqAddr", bus.RdRqAddr, '0);
    checkEq("rst RspValid", bus.RspValid, '0);
    checkEq("rst RspErr", bus.RspErr, '0);
    checkEq("rst RspDone", bus.RspDone, '0);
    checkEq("rst RspData", bus.RspData, '0);
    dReady = 1'b0;
    dErr   = 1'b0;
    bus.RdRqReady = 1'b0;
    bus.RdRqErr   = 1'b0;
    for (int q = 0; q < int'(NREQ); q++) randDesc(q);
    bus.ReqValid = pend;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    lastG    = int'(NREQ) - 1;
    portFree = 1'b1;
    inBurst  = 1'b0;
    closing  = 1'b0;
    predict();
  endtask

  initial begin
    bus.ReqValid  = '0;
    bus.ReqAddr   = '0;
    bus.ReqLen    = '0;
    bus.RdRqData  = '0;
    bus.RdRqReady = 1'b0;
    bus.RdRqErr   = 1'b0;
    pend     = '0;
    lastG    = int'(NREQ) - 1;
    portFree = 1'b1;
    inBurst  = 1'b0;
    closing  = 1'b0;
    stall    = 1'b0;
    didReset = 1'b0;
    nBursts  = 0;
    g = 0; bLen = 0; bBeat = 0; silent = 0; cyc = 0;
    bAddr = '0; eAddr = '0; eData = '0;
    eAck = '0; eRspV = '0; eErr = '0; eDone = '0; eValid = 1'b0;
    dReady = 1'b0; dErr = 1'b0; dData = '0;

    repeat (3) @(negedge clk);
    checkOutputs();
    checkEq("rst RdRqAddr", bus.RdRqAddr, '0);
    checkEq("rst RspData", bus.RspData, '0);

    // Opening sequence: plain burst, address wrap, zero-length burst
    setDesc(0, 64'h0000_0000_0000_1000, 3);
    setDesc(1, 64'hFFFF_FFFF_FFFF_FFF7, 2);
    setDesc(2, 64'h0000_0000_0000_2000, 0);
    bus.ReqValid = pend;
    rst_n = 1'b1;
    predict();

    for (int i = 0; i < CYCLES; i++) begin
      @(negedge clk);
      cyc = i;
      checkOutputs();
      if (i >= 2000 && !didReset && inBurst) begin
        didReset = 1'b1;
        doReset();
      end else begin
        drive();
        predict();
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pcie_rd_arbiter.md
Name: pcie_rd_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares the single PCIe read-request controller port (RdRqValid/RdRqAddr/RdRqData/RdRqReady/RdRqErr) between NUM_REQ DMA read requesters.
- Accepts one burst descriptor (base address, beat count) per grant and issues one 128-bit read per beat at incrementing 16-byte addresses.
- Returns each beat to the granted requester, then releases the port.
- Sits between the DMA channel engines and pcie_sub_ctlr's read-request interface.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- LEN_W, 8, width of the burst beat count.
- TIMEOUT_W, 6, width of the per-beat no-response watchdog counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ReqValid  in  NUM_REQ  per-requester burst request; held until ReqAck.
- ReqAddr  in  NUM_REQ*64  per-requester base byte address; bits [3:0] ignored.
- ReqLen  in  NUM_REQ*LEN_W  per-requester beat count.
- ReqAck  out  NUM_REQ  one-hot, 1-cycle pulse; descriptor captured.
- RspData  out  128  returned read data (shared bus).
- RspValid  out  NUM_REQ  one-hot, 1-cycle pulse per returned beat.
- RspErr  out  NUM_REQ  one-hot, 1-cycle pulse; burst aborted.
- RspDone  out  NUM_REQ  one-hot, 1-cycle pulse; burst finished, normal or aborted.
- RdRqValid  out  1  read request to controller.
- RdRqAddr  out  64  read byte address, 16B aligned.
- RdRqData  in  128  controller read data; valid with RdRqReady.
- RdRqReady  in  1  1-cycle pulse; beat completed.
- RdRqErr  in  1  1-cycle pulse; beat failed.

Behaviour:
- Reset: all outputs 0; state IDLE; last-grant pointer = NUM_REQ-1, so requester 0 has top priority first; beat counter and watchdog are 0.
- Reset mid-burst drops RdRqValid asynchronously. No RspDone is generated for the interrupted burst.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, arbitration:
  - If any ReqValid, pick the first set bit searching from last_grant+1 with wrap-around.
  - In the same cycle, latch grant g, ReqAddr[g] with [3:0]=0, and ReqLen[g]; pulse ReqAck[g].
  - Go to ISSUE, or to DONE if ReqLen[g]==0.
- ISSUE:
  - RdRqValid=1 continuously. RdRqAddr = latched base + 16*beat, registered; wraps modulo 2^64.
  - On RdRqReady with RdRqErr=0: capture RdRqData into RspData and pulse RspValid[g] the next cycle (latency 1). Increment beat; RdRqAddr advances by 16 from the next cycle.
  - If that was beat ReqLen-1, go to DONE; RdRqValid=0 from the next cycle.
  - On RdRqErr, with or without RdRqReady (Err wins): pulse RspErr[g] the next cycle, drop RdRqValid, go to DONE. No RspValid is issued for that beat.
  - Watchdog counts cycles in ISSUE since the last Ready/Err/entry. When it reaches 2^TIMEOUT_W-1 it is treated exactly as RdRqErr.
- DONE:
  - RdRqValid=0; pulse RspDone[g]; last_grant=g; go to IDLE.
  - This guarantees at least 2 cycles between bursts and one idle cycle of RdRqValid.
- RspErr for an abort appears on the cycle DONE is entered; RspDone follows 1 cycle later.
- ReqValid changes while a request is not acknowledged are legal and simply re-evaluated in IDLE. Inputs of non-granted requesters are never sampled outside IDLE.
- ReqLen is interpreted as unsigned; max burst is 2^LEN_W-1 beats.

Decomposition:
- Package pcie_dma_pkg holds:
  - DATA_W=128, ADDR_W=64, BEAT_BYTES=16;
  - typedef enum rd_arb_state_e {IDLE, ISSUE, DONE};
  - typedef rd_desc_t struct {addr, len}.
- Sub-module rr_arbiter, parameterised NUM_REQ: combinational round-robin select given a request vector and last-grant pointer; outputs a one-hot grant and a grant index.

Test Plan:
- Single burst: ReqValid[0], addr 0x1000, len 3; Ready every 2nd cycle with data A, B, C -> RdRqAddr 0x1000, 0x1010, 0x1020; RspValid[0] with A, B, C one cycle after each Ready; RspDone[0]; RdRqValid low afterwards.
- Fairness: NUM_REQ=4, ReqValid=4'b0111 held and re-asserted, each len 1 -> ReqAck order 0, 1, 2, 0, 1, 2; requester 3 asserts later and is served after the current grant, before the wrap to 0.
- Error abort: len 4; RdRqErr on the 2nd beat -> exactly 1 RspValid; RspErr then RspDone next cycle; no further RdRqValid for that burst.
- Ready and Err in the same cycle: RspErr asserted; no RspValid; RspData not used.
- Timeout with TIMEOUT_W=4 and no Ready -> RspErr 15 cycles after ISSUE entry, then RspDone; the next requester is granted.
- Edge cases:
  - len 0 -> ReqAck, then RspDone with no RdRqValid.
  - addr 0xFFFF_FFFF_FFFF_FFF7, len 2 -> RdRqAddr 0x…FFF0, then 0x0.
  - rst_n low mid-burst -> all outputs 0 immediately; requester 0 is granted first afterwards.
